// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the sequential execute-stage ALU.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_XOR  = 5'd0,
        OP_SLL  = 5'd1,
        OP_SLL2 = 5'd2,
        OP_SRL  = 5'd3,
        OP_SUB  = 5'd4,
        OP_SRL2 = 5'd5,
        OP_SLT  = 5'd6,
        OP_ZERO = 5'd7,
        OP_SUB2 = 5'd8,
        OP_OR   = 5'd9,
        OP_NOR  = 5'd10,
        OP_ADD  = 5'd11,
        OP_MULT = 5'd12,
        OP_DIV  = 5'd13,
        OP_AND  = 5'd14,
        OP_ADD2 = 5'd15,
        OP_SRA  = 5'd16,
        OP_EQ   = 5'd17,
        OP_NE   = 5'd18,
        OP_LEZ  = 5'd19,
        OP_GTZ  = 5'd20,
        OP_GEZ  = 5'd21,
        OP_LUI  = 5'd22
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } seq_alu_state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Issue/result handshake bundle between the EX-stage pipeline and seq_alu.
interface seq_alu_if #(parameter int unsigned WIDTH = 32);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  alu_control;
    logic [WIDTH-1:0] reg1_data;
    logic [WIDTH-1:0] reg2_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             z_flag;
    logic             div_zero;

    modport master (
        output in_valid, alu_control, reg1_data, reg2_data, out_ready,
        input  in_ready, out_valid, result, result_hi, z_flag, div_zero
    );

    modport slave (
        input  in_valid, alu_control, reg1_data, reg2_data, out_ready,
        output in_ready, out_valid, result, result_hi, z_flag, div_zero
    );

endinterface

// File: rtl/seq_muldiv_core.sv
// Iterative signed multiply / restoring divide on operand magnitudes, one bit per cycle.
module seq_muldiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dz_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic                 busy_q, op_q, dz_q, neg_q, sa_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     hi_q, lo_q, b_q;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       add_s, rem_sh, diff;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     hi_d, lo_d;

    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag = b_i[WIDTH-1] ? -b_i : b_i;

    assign add_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rem_sh = {hi_q, lo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, b_q};

    always_comb begin
        if (op_q) begin
            hi_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_d = add_s[WIDTH:1];
            lo_d = {add_s[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            op_q   <= 1'b0;
            dz_q   <= 1'b0;
            neg_q  <= 1'b0;
            sa_q   <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            op_q   <= op_i;
            dz_q   <= op_i && (b_i == '0);
            neg_q  <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            sa_q   <= a_i[WIDTH-1];
            cnt_q  <= '0;
            hi_q   <= (op_i && (b_i == '0)) ? a_i : '0;
            lo_q   <= a_mag;
            b_q    <= b_mag;
        end else if (busy_q) begin
            if (dz_q) begin
                busy_q <= 1'b0;
            end else begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1))
                    busy_q <= 1'b0;
            end
        end
    end

    assign done_o = busy_q && (dz_q || (cnt_q == CW'(WIDTH - 1)));
    assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign dz_o   = dz_q;

    always_comb begin
        if (dz_q) begin
            lo_o = '1;
            hi_o = hi_q;
        end else if (op_q) begin
            lo_o = neg_q ? -lo_q : lo_q;
            hi_o = sa_q ? -hi_q : hi_q;
        end else begin
            lo_o = prod_s[WIDTH-1:0];
            hi_o = prod_s[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU: single-cycle ops registered at accept, MULT/DIV via the iterative core.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    seq_alu_state_e   state_q;
    logic             out_valid_q, z_q, dz_q;
    logic [WIDTH-1:0] result_q, hi_q, alu_res, core_hi, core_lo;
    logic [SHW-1:0]   shamt;
    logic             accept, is_mul, is_div, core_done, core_dz;

    assign bus.in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mul       = bus.alu_control == OP_MULT;
    assign is_div       = bus.alu_control == OP_DIV;
    assign shamt        = bus.reg1_data[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.alu_control)
            OP_XOR:           alu_res = bus.reg1_data ^ bus.reg2_data;
            OP_SLL, OP_SLL2:  alu_res = bus.reg2_data << shamt;
            OP_SRL, OP_SRL2:  alu_res = bus.reg2_data >> shamt;
            OP_SUB, OP_SUB2:  alu_res = bus.reg1_data - bus.reg2_data;
            OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.reg1_data) < $signed(bus.reg2_data)};
            OP_OR:            alu_res = bus.reg1_data | bus.reg2_data;
            OP_NOR:           alu_res = ~(bus.reg1_data | bus.reg2_data);
            OP_ADD, OP_ADD2:  alu_res = bus.reg1_data + bus.reg2_data;
            OP_AND:           alu_res = bus.reg1_data & bus.reg2_data;
            OP_SRA:           alu_res = $signed(bus.reg2_data) >>> shamt;
            OP_EQ:            alu_res = {{(WIDTH-1){1'b0}}, bus.reg1_data == bus.reg2_data};
            OP_NE:            alu_res = {{(WIDTH-1){1'b0}}, bus.reg1_data != bus.reg2_data};
            OP_LEZ:           alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.reg1_data) <= 0};
            OP_GTZ:           alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.reg1_data) > 0};
            OP_GEZ:           alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.reg1_data) >= 0};
            OP_LUI:           alu_res = bus.reg2_data << (WIDTH / 2);
            default:          alu_res = '0;
        endcase
    end

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && (is_mul || is_div)),
        .op_i    (is_div),
        .a_i     (bus.reg1_data),
        .b_i     (bus.reg2_data),
        .done_o  (core_done),
        .hi_o    (core_hi),
        .lo_o    (core_lo),
        .dz_o    (core_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            z_q         <= 1'b1;
            dz_q        <= 1'b0;
        end else begin
            // A consumed result drops valid unless a new one lands on this same edge.
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q <= S_MUL;
                        end else if (is_div) begin
                            state_q <= S_DIV;
                        end else begin
                            result_q    <= alu_res;
                            hi_q        <= '0;
                            z_q         <= (alu_res == '0);
                            dz_q        <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (core_done)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    result_q    <= core_lo;
                    hi_q        <= core_hi;
                    z_q         <= (core_lo == '0);
                    dz_q        <= core_dz;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = hi_q;
    assign bus.z_flag    = z_q;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus randomized traffic with random backpressure.
module tb_seq_alu;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy_force, rdy_rnd, rnd_on;
    int unsigned n_tests, n_fail, cyc;
    exp_t        exp_q[$];

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.out_ready = rnd_on ? rdy_rnd : rdy_force;

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p;
        int unsigned sh = a[4:0];
        e = '0;
        case (op)
            5'd0:        e.lo = a ^ b;
            5'd1, 5'd2:  e.lo = b << sh;
            5'd3, 5'd5:  e.lo = b >> sh;
            5'd4, 5'd8:  e.lo = a - b;
            5'd6:        e.lo = 32'(sa < sb);
            5'd9:        e.lo = a | b;
            5'd10:       e.lo = ~(a | b);
            5'd11, 5'd15: e.lo = a + b;
            5'd12: begin
                p = sa * sb;
                e.lo = p[31:0];
                e.hi = p[63:32];
            end
            5'd13: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    p = sa / sb;
                    e.lo = p[31:0];
                    p = sa % sb;
                    e.hi = p[31:0];
                end
            end
            5'd14:       e.lo = a & b;
            5'd16: begin
                p = sb >>> sh;
                e.lo = p[31:0];
            end
            5'd17:       e.lo = 32'(a == b);
            5'd18:       e.lo = 32'(a != b);
            5'd19:       e.lo = 32'(sa <= 0);
            5'd20:       e.lo = 32'(sa > 0);
            5'd21:       e.lo = 32'(sa >= 0);
            5'd22:       e.lo = b << 16;
            default:     e.lo = 32'd0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int unsigned acc);
        int unsigned w = 0;
        bus.alu_control = op;
        bus.reg1_data   = a;
        bus.reg2_data   = b;
        bus.in_valid    = 1'b1;
        #1;
        while (!bus.in_ready && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (bus.in_ready) begin
            acc = cyc + 1;
            exp_q.push_back(model(op, a, b));
        end else begin
            chk("accept_timeout", bus.in_ready, 1);
            acc = 0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int unsigned edge_idx, output bit rdy_seen);
        int unsigned w = 0;
        rdy_seen = 1'b0;
        #3;
        while (!bus.out_valid && w < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            #3;
            w++;
        end
        if (!bus.out_valid) chk("valid_timeout", bus.out_valid, 1);
        edge_idx = cyc;
        @(negedge clk);
    endtask

    task automatic drain();
        int unsigned w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    initial begin
        int unsigned a1, a2, ev;
        bit          rs;
        bit          stale;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; rdy_force = 1'b1; rdy_rnd = 1'b1; rnd_on = 1'b0;
        bus.in_valid = 1'b0; bus.alu_control = '0; bus.reg1_data = '0; bus.reg2_data = '0;

        fork
            forever @(posedge clk) cyc++;
            forever begin
                @(negedge clk);
                rdy_rnd = ($urandom_range(3) != 0);
            end
            forever begin
                exp_t e;
                @(negedge clk);
                #2;
                if (rst_n && bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", bus.out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", bus.result, e.lo);
                        chk("result_hi", bus.result_hi, e.hi);
                        chk("z_flag", bus.z_flag, e.lo == 32'd0);
                        chk("div_zero", bus.div_zero, e.dz);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", {bus.result_hi, bus.result}, 0);
        chk("rst_flags", {bus.z_flag, bus.div_zero}, 2'b10);
        rst_n = 1'b1;
        @(negedge clk);

        issue(5'd11, 32'd5, -32'sd7, a1);
        chk("add_latency", bus.out_valid, 1);
        issue(5'd4, 32'd9, 32'd9, a2);
        chk("b2b_accept", a2, a1 + 1);
        drain();

        issue(5'd12, -32'sd3, 32'd7, a1);
        wait_valid(ev, rs);
        chk("mul_latency", ev - a1, 33);
        chk("mul_in_ready_low", rs, 0);

        issue(5'd13, -32'sd7, 32'd2, a1);
        issue(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, a1);
        drain();

        issue(5'd13, 32'd100, 32'd0, a1);
        wait_valid(ev, rs);
        chk("div0_latency", ev - a1, 2);
        issue(5'd11, 32'd1, 32'd1, a1);
        drain();

        rdy_force = 1'b0;
        issue(5'd16, 32'd4, 32'hF000_0000, a1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_result", bus.result, 32'hFF00_0000);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            @(negedge clk);
        end
        rdy_force = 1'b1;
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        drain();

        issue(5'd12, 32'd1234, 32'd5678, a1);
        repeat (9) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_release_ready", bus.in_ready, 1);
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) stale = 1'b1;
        end
        chk("abort_no_stale", stale, 0);

        rnd_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(31));
            issue(op, rnd_val(), rnd_val(), a1);
        end
        rnd_on = 1'b0;
        rdy_force = 1'b1;
        drain();
        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked, multi-cycle successor to the combinational execute-stage ALU.
- Uses the same 5-bit alu_control encoding (0..22).
- Adds an iterative signed multiplier and divider that produce a full HI/LO pair, a valid/ready handshake on both sides, and a divide-by-zero flag.
- Sits in the EX stage; the pipeline stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- alu_control  in  5  opcode, same encoding as the existing ALU
- reg1_data  in  WIDTH  operand A (signed)
- reg2_data  in  WIDTH  operand B (signed)
- out_valid  out  1  result registers hold a completed result
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  LO / main result
- result_hi  out  WIDTH  MULT high word, DIV remainder; 0 for other ops
- z_flag  out  1  result == 0
- div_zero  out  1  completed DIV had reg2_data == 0

Behaviour:
- Reset (async, rst_n low): state=IDLE; out_valid=0; result=0; result_hi=0; z_flag=1; div_zero=0; in_ready=0 while rst_n is low.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted when in_valid && in_ready.
  - Outputs hold stable while out_valid && !out_ready.
- Single-cycle ops (all codes except 12, 13):
  - Result is registered at the accept edge; out_valid rises the next cycle (latency 1).
  - Back-to-back issue is allowed: a full-throughput stream when out_ready is held high.
- Opcode semantics (unchanged from the existing ALU):
  - 0 XOR. 1/2 SLL (B << A[SHW-1:0]). 3/5 SRL logical. 4/8 SUB. 6 SLT signed. 7 → 0. 9 OR. 10 NOR. 11/15 ADD (wraps, no overflow trap). 14 AND. 16 SRA arithmetic.
  - 17 EQ, 18 NE → 1 or 0.
  - 19 A<=0, 20 A>0, 21 A>=0 → 1 or 0.
  - 22 LUI: B << (WIDTH/2).
  - 23–31 → 0.
  - Shift amounts use only the low SHW bits of A.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE → MUL on accepting opcode 12; IDLE → DIV on accepting opcode 13.
  - MUL: radix-2 signed iterative multiply. Operands are captured as magnitudes with the sign remembered. Exactly WIDTH iteration cycles, then the 2·WIDTH product is negated if the signs differ. → DONE.
  - DIV: restoring unsigned division on magnitudes, WIDTH iteration cycles. Quotient sign = signA^signB; remainder sign = signA (truncate toward zero). → DONE.
  - DONE: writes result/result_hi/z_flag/div_zero, sets out_valid, → IDLE. Total latency accept→out_valid = WIDTH+1 cycles.
- Divide by zero:
  - No iteration; DIV → DONE after 1 cycle.
  - result = all ones, result_hi = dividend, div_zero=1.
  - div_zero is cleared on the next completed op.
- Edge case: the most negative value MULT/DIV uses magnitude 2^(WIDTH-1) in WIDTH+1-bit internal arithmetic.
  - MIN/-1: quotient = MIN, remainder = 0.
- Simultaneity: the result handoff (out_ready) and a new accept in the same cycle are legal. The new result overwrites on the following edge, and out_valid stays 1.
- z_flag is computed from the registered result, not from result_hi.
- Reset asserted mid-MUL/DIV aborts the operation with no output; the block returns to reset values.

Decomposition:
- Shared package alu_pkg:
  - enum alu_op_e with the 23 opcode names and values 0..22.
  - State enum seq_alu_state_e.
  - Constant OP_W=5.
- One natural sub-module: seq_muldiv_core (WIDTH parameter).
  - Owns the iteration counter, shift registers and sign fix-up.
  - Signals: start/op/a/b in; done/hi/lo/dz out.
  - The top keeps the handshake, combinational ops and output registers.

Test Plan (WIDTH=32):
- ADD 5+(-7) with out_ready=1 → out_valid next cycle; result=0xFFFFFFFE, z_flag=0. Then SUB 9-9 back-to-back → result=0, z_flag=1; in_ready never drops.
- MULT -3×7 → out_valid exactly 33 cycles after accept; result=0xFFFFFFEB, result_hi=0xFFFFFFFF. in_ready=0 throughout.
- DIV -7/2 → result=0xFFFFFFFD, result_hi=0xFFFFFFFF, div_zero=0. DIV 0x80000000/-1 → result=0x80000000, result_hi=0.
- DIV 100/0 → out_valid 2 cycles after accept; result=0xFFFFFFFF, result_hi=100, div_zero=1. The next ADD clears div_zero.
- Backpressure: SRA 0xF0000000 by 4 with out_ready=0 for 5 cycles → result holds 0xFF000000, in_ready=0. Raising out_ready makes in_ready rise the same cycle.
- Reset mid-op: drop rst_n at cycle 10 of MULT → out_valid=0 and result=0 immediately (async). After release, in_ready=1 and no stale result appears.
